// File: rtl/rx_payload_enq_alloc_pkg.sv
// Shared types for the RX payload enqueue allocator.
// Widths, FSM states and the response bundle.
package rx_payload_enq_alloc_pkg;

  localparam int RX_FLOW_ID_W        = 8;
  localparam int RX_PAYLOAD_Q_SIZE_W = 7;
  localparam int RX_PAYLOAD_PTR_W    = RX_PAYLOAD_Q_SIZE_W + 1;
  localparam int RX_DROP_CNT_W       = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUERY,
    ST_WAIT_RESP,
    ST_WR_TAIL,
    ST_RESP
  } rx_enq_state_e;

  typedef struct packed {
    logic                           accept;
    logic [RX_PAYLOAD_Q_SIZE_W-1:0] slot;
    logic [RX_FLOW_ID_W-1:0]        flowid;
  } rx_enq_resp_struct;

endpackage

// File: rtl/rx_payload_enq_alloc_if.sv
// Handshake bundle around the RX payload enqueue allocator.
// slave = allocator side, master = surrounding pipe/memories.
interface rx_payload_enq_alloc_if #(
  parameter int FLOW_ID_W = 8,
  parameter int Q_SIZE_W  = 7
);
  logic                 enq_req_val;
  logic [FLOW_ID_W-1:0] enq_req_flowid;
  logic                 enq_req_rdy;

  logic                 q_full_req_val;
  logic [FLOW_ID_W-1:0] q_full_req_flowid;
  logic                 q_full_req_rdy;

  logic                 q_full_resp_val;
  logic [Q_SIZE_W:0]    q_full_resp_head_index;
  logic [Q_SIZE_W:0]    q_full_resp_tail_index;
  logic                 q_full_resp_rdy;

  logic                 tail_ptr_wr_req_val;
  logic [FLOW_ID_W-1:0] tail_ptr_wr_req_addr;
  logic [Q_SIZE_W:0]    tail_ptr_wr_req_data;
  logic                 tail_ptr_wr_req_rdy;

  logic                 enq_resp_val;
  logic                 enq_resp_accept;
  logic [Q_SIZE_W-1:0]  enq_resp_slot;
  logic [FLOW_ID_W-1:0] enq_resp_flowid;
  logic                 enq_resp_rdy;

  modport slave (
    input  enq_req_val, enq_req_flowid,
    output enq_req_rdy,
    output q_full_req_val, q_full_req_flowid,
    input  q_full_req_rdy,
    input  q_full_resp_val, q_full_resp_head_index,
    input  q_full_resp_tail_index,
    output q_full_resp_rdy,
    output tail_ptr_wr_req_val, tail_ptr_wr_req_addr,
    output tail_ptr_wr_req_data,
    input  tail_ptr_wr_req_rdy,
    output enq_resp_val, enq_resp_accept,
    output enq_resp_slot, enq_resp_flowid,
    input  enq_resp_rdy
  );

  modport master (
    output enq_req_val, enq_req_flowid,
    input  enq_req_rdy,
    input  q_full_req_val, q_full_req_flowid,
    output q_full_req_rdy,
    output q_full_resp_val, q_full_resp_head_index,
    output q_full_resp_tail_index,
    input  q_full_resp_rdy,
    input  tail_ptr_wr_req_val, tail_ptr_wr_req_addr,
    input  tail_ptr_wr_req_data,
    output tail_ptr_wr_req_rdy,
    input  enq_resp_val, enq_resp_accept,
    input  enq_resp_slot, enq_resp_flowid,
    output enq_resp_rdy
  );
endinterface

// File: rtl/rx_payload_enq_alloc_q_ptr_full_check.sv
// Head/tail pointer classification for a per-flow ring.
// MSB of each pointer is the wrap bit.
module rx_q_ptr_full_check #(
  parameter int Q_SIZE_W = 7
) (
  input  logic [Q_SIZE_W:0] head,
  input  logic [Q_SIZE_W:0] tail,
  output logic              full,
  output logic              empty,
  output logic [Q_SIZE_W:0] next_tail
);
  localparam int PTR_W = Q_SIZE_W + 1;

  // Same slot on opposite laps is full; same lap is empty.
  always_comb begin
    full      = (head[Q_SIZE_W] != tail[Q_SIZE_W]) &&
                (head[Q_SIZE_W-1:0] == tail[Q_SIZE_W-1:0]);
    empty     = (head == tail);
    next_tail = tail + PTR_W'(1);
  end
endmodule

// File: rtl/rx_payload_enq_alloc.sv
// RX payload enqueue allocator: query fullness, bump tail, answer.
// One request in flight, so no tail read-after-write hazard.
module rx_payload_enq_alloc
  import rx_payload_enq_alloc_pkg::*;
#(
  parameter int FLOW_ID_W  = RX_FLOW_ID_W,
  parameter int Q_SIZE_W   = RX_PAYLOAD_Q_SIZE_W,
  parameter int DROP_CNT_W = RX_DROP_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  rx_payload_enq_alloc_if.slave bus,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  rx_enq_state_e         state_q, state_d;
  rx_enq_resp_struct     resp_q, resp_d;
  logic [Q_SIZE_W:0]     wr_data_q, wr_data_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic enq_req_rdy_q, enq_req_rdy_d;
  logic q_req_val_q, q_req_val_d;
  logic q_resp_rdy_q, q_resp_rdy_d;
  logic wr_val_q, wr_val_d;
  logic resp_val_q, resp_val_d;

  logic              q_full;
  logic              unused_q_empty;
  logic [Q_SIZE_W:0] q_next_tail;

  rx_q_ptr_full_check #(
    .Q_SIZE_W (Q_SIZE_W)
  ) u_full_check (
    .head      (bus.q_full_resp_head_index),
    .tail      (bus.q_full_resp_tail_index),
    .full      (q_full),
    .empty     (unused_q_empty),
    .next_tail (q_next_tail)
  );

  // Next-state, latched bundle and drop count; outputs decode state_d.
  always_comb begin
    state_d    = state_q;
    resp_d     = resp_q;
    wr_data_d  = wr_data_q;
    drop_cnt_d = drop_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.enq_req_val) begin
          resp_d.flowid = bus.enq_req_flowid;
          resp_d.accept = 1'b0;
          resp_d.slot   = '0;
          state_d       = ST_QUERY;
        end
      end
      ST_QUERY: begin
        if (bus.q_full_req_rdy) state_d = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (bus.q_full_resp_val) begin
          if (q_full) begin
            resp_d.accept = 1'b0;
            resp_d.slot   = '0;
            if (!(&drop_cnt_q))
              drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            state_d = ST_RESP;
          end else begin
            resp_d.accept = 1'b1;
            resp_d.slot   =
              bus.q_full_resp_tail_index[Q_SIZE_W-1:0];
            wr_data_d     = q_next_tail;
            state_d       = ST_WR_TAIL;
          end
        end
      end
      ST_WR_TAIL: begin
        if (bus.tail_ptr_wr_req_rdy) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.enq_resp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    enq_req_rdy_d = (state_d == ST_IDLE);
    q_req_val_d   = (state_d == ST_QUERY);
    q_resp_rdy_d  = (state_d == ST_WAIT_RESP);
    wr_val_d      = (state_d == ST_WR_TAIL);
    resp_val_d    = (state_d == ST_RESP);
  end

  // State and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      resp_q        <= '0;
      wr_data_q     <= '0;
      drop_cnt_q    <= '0;
      enq_req_rdy_q <= 1'b1;
      q_req_val_q   <= 1'b0;
      q_resp_rdy_q  <= 1'b0;
      wr_val_q      <= 1'b0;
      resp_val_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      resp_q        <= resp_d;
      wr_data_q     <= wr_data_d;
      drop_cnt_q    <= drop_cnt_d;
      enq_req_rdy_q <= enq_req_rdy_d;
      q_req_val_q   <= q_req_val_d;
      q_resp_rdy_q  <= q_resp_rdy_d;
      wr_val_q      <= wr_val_d;
      resp_val_q    <= resp_val_d;
    end
  end

  assign bus.enq_req_rdy          = enq_req_rdy_q;
  assign bus.q_full_req_val       = q_req_val_q;
  assign bus.q_full_req_flowid    = resp_q.flowid;
  assign bus.q_full_resp_rdy      = q_resp_rdy_q;
  assign bus.tail_ptr_wr_req_val  = wr_val_q;
  assign bus.tail_ptr_wr_req_addr = resp_q.flowid;
  assign bus.tail_ptr_wr_req_data = wr_data_q;
  assign bus.enq_resp_val         = resp_val_q;
  assign bus.enq_resp_accept      = resp_q.accept;
  assign bus.enq_resp_slot        = resp_q.slot;
  assign bus.enq_resp_flowid      = resp_q.flowid;
  assign drop_cnt                 = drop_cnt_q;

endmodule
